// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx among three FIFO-buffered byte producers
module uart_tx_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int TX_TIMEOUT = 124992
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  in_valid,
  input  logic [23:0] in_data,
  output logic [2:0]  in_ready,
  input  logic        clear_err,
  output logic        tx_start,
  output logic [7:0]  tx_din,
  input  logic        tx_active,
  input  logic        tx_done,
  output logic        busy,
  output logic [1:0]  grant_id,
  output logic [2:0]  overflow_err,
  output logic        timeout_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TX_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;
  state_t state, state_nx;
  logic [7:0] mem [3][FIFO_DEPTH];
  logic [AW-1:0] wp [3];
  logic [AW-1:0] rp [3];
  logic [CW-1:0] cnt [3];
  logic [WW-1:0] wd;
  logic [1:0] last_grant, p1, p2, sel;
  logic [2:0] ne, wr, pop;
  logic go, expire;
  // per-port occupancy flags from the registered counts
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      ne[k] = cnt[k] != '0;
      in_ready[k] = cnt[k] != CW'(FIFO_DEPTH);
    end
  end
  // round-robin pick starting after the last grant; grant only when uart_tx is idle
  always_comb begin
    p1 = last_grant == 2'd2 ? 2'd0 : last_grant + 2'd1;
    p2 = p1 == 2'd2 ? 2'd0 : p1 + 2'd1;
    sel = ne[p1] ? p1 : ne[p2] ? p2 : last_grant;
    go = state == IDLE && !tx_active && |ne;
    pop = go ? 3'b001 << sel : 3'b000;
    wr = in_valid & in_ready;
    expire = wd == WW'(TX_TIMEOUT - 1);
    busy = state != IDLE;
  end
  // next state and start pulse
  always_comb begin
    state_nx = state;
    tx_start = 1'b0;
    case (state)
      IDLE: state_nx = go ? ISSUE : IDLE;
      ISSUE: begin
        tx_start = 1'b1;
        state_nx = WAIT_DONE;
      end
      WAIT_DONE: state_nx = tx_done || expire ? IDLE : WAIT_DONE;
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // FIFOs, grant registers, watchdog and sticky errors
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        wp[k] <= '0;
        rp[k] <= '0;
        cnt[k] <= '0;
      end
      tx_din <= '0;
      grant_id <= '0;
      last_grant <= 2'd2;
      wd <= '0;
      overflow_err <= '0;
      timeout_err <= 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (wr[k]) begin
          mem[k][wp[k]] <= in_data[8*k +: 8];
          wp[k] <= wp[k] + 1'b1;
        end
        if (pop[k]) rp[k] <= rp[k] + 1'b1;
        cnt[k] <= cnt[k] + CW'(wr[k]) - CW'(pop[k]);
      end
      if (go) begin
        tx_din <= mem[sel][rp[sel]];
        grant_id <= sel;
      end
      wd <= state == WAIT_DONE ? wd + 1'b1 : '0;
      if (state == WAIT_DONE && (tx_done || expire)) last_grant <= grant_id;
      overflow_err <= (overflow_err & ~{3{clear_err}}) | (in_valid & ~in_ready);
      timeout_err <= (timeout_err & ~clear_err) | (state == WAIT_DONE && !tx_done && expire);
    end
  end
endmodule
